ir_key_scheduler: RTL and testbench

- Sits downstream of the IR receiver and turns raw 32-bit NEC frames (i_FRAME/i_FRAME_READY) into key events: PRESS, REPEAT (auto-repeat while held) and RELEASE.
- Filters frames by address integrity and device address, and tracks hold/repeat timing.
- Buffers events in a small FIFO behind a valid/ready handshake so a slow consumer (CPU, UART bridge) can pace them.

---
 rtl/ir_pkg.sv | 40 ++++
 rtl/ir_event_fifo.sv | 49 ++++
 rtl/ir_key_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_ir_key_scheduler.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ir_pkg.sv
// Shared types and constants for the NEC IR key scheduler: event encoding,
// FSM state encoding and the byte layout of a received 32-bit frame.
package ir_pkg;

    localparam logic [1:0] EV_PRESS   = 2'b01;
    localparam logic [1:0] EV_REPEAT  = 2'b10;
    localparam logic [1:0] EV_RELEASE = 2'b11;

    // Low bit of each byte field within a frame.
    localparam int ADDR   = 0;
    localparam int ADDR_N = 8;
    localparam int CMD    = 16;
    localparam int CMD_N  = 24;

    localparam int CNT_W = 25;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_HELD_DELAY  = 2'd1,
        ST_HELD_REPEAT = 2'd2,
        ST_PRESS_PEND  = 2'd3
    } ir_state_e;

    typedef struct packed {
        logic [1:0] ev_type;
        logic [7:0] code;
    } ir_event_t;

    function automatic logic [7:0] frame_byte(input logic [31:0] frame, input int lo);
        return frame[lo +: 8];
    endfunction

    function automatic ir_event_t make_event(input logic [1:0] ev_type, input logic [7:0] code);
        ir_event_t ev;
        ev.ev_type = ev_type;
        ev.code    = code;
        return ev;
    endfunction

endpackage

// File: rtl/ir_event_fifo.sv
// Show-ahead synchronous FIFO; a push into a full FIFO is accepted only when
// a pop happens on the same edge, otherwise it is discarded.
module ir_event_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is not reset; empty/valid come from the pointers, so stale
    // contents are never observed and the array can map onto plain RAM.
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/ir_key_scheduler.sv
// Converts NEC frames into PRESS / REPEAT / RELEASE key events, tracking hold
// and auto-repeat timing, and queues the events behind a valid/ready port.
module ir_key_scheduler
    import ir_pkg::*;
#(
    parameter logic [7:0] DEVICE_ADDR    = 8'h00,
    parameter bit         ADDR_FILTER_EN = 1'b1,
    parameter int         HOLD_WINDOW    = 6_000_000,
    parameter int         REPEAT_DELAY   = 25_000_000,
    parameter int         REPEAT_PERIOD  = 5_000_000,
    parameter int         FIFO_DEPTH     = 4
) (
    input  logic        i_CLOCK_POS,
    input  logic        i_RESET_POS,
    input  logic        i_FRAME_READY,
    input  logic [31:0] i_FRAME,
    input  logic        i_EVENT_READY,
    input  logic        i_CLEAR_OVF,
    output logic        o_EVENT_VALID,
    output logic [1:0]  o_EVENT_TYPE,
    output logic [7:0]  o_EVENT_CODE,
    output logic        o_KEY_HELD,
    output logic [7:0]  o_HELD_CODE,
    output logic        o_OVERFLOW,
    output logic [7:0]  o_REJECT_COUNT
);

    localparam logic [CNT_W-1:0] WIN_LAST   = CNT_W'(HOLD_WINDOW - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    ir_state_e        r_state;
    ir_state_e        w_state_next;
    logic             r_frame_ready_d;
    logic [7:0]       r_held_code;
    logic [7:0]       w_held_next;
    logic [CNT_W-1:0] r_win_cnt;
    logic [CNT_W-1:0] w_win_next;
    logic [CNT_W-1:0] r_rep_cnt;
    logic [CNT_W-1:0] w_rep_next;
    logic [CNT_W-1:0] w_rep_inc;
    logic [CNT_W-1:0] w_rep_last;
    logic             r_overflow;
    logic [7:0]       r_reject_cnt;

    logic             w_strobe;
    logic             w_frame_ok;
    logic             w_accept;
    logic [7:0]       w_cmd;
    logic             w_push;
    ir_event_t        w_push_ev;
    logic             w_pop;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    ir_event_t        w_head;

    assign w_strobe   = i_FRAME_READY && !r_frame_ready_d;
    assign w_cmd      = frame_byte(i_FRAME, CMD);
    assign w_frame_ok = (frame_byte(i_FRAME, ADDR_N) == ~frame_byte(i_FRAME, ADDR)) &&
                        (frame_byte(i_FRAME, CMD_N)  == ~w_cmd) &&
                        (!ADDR_FILTER_EN || frame_byte(i_FRAME, ADDR) == DEVICE_ADDR);
    assign w_accept   = w_strobe && w_frame_ok;

    assign w_rep_inc  = (&r_rep_cnt) ? r_rep_cnt : r_rep_cnt + 1'b1;
    assign w_rep_last = (r_state == ST_HELD_DELAY) ? DELAY_LAST : PERIOD_LAST;

    // NOTE: every signal driven here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_held_next  = r_held_code;
        w_win_next   = r_win_cnt;
        w_rep_next   = r_rep_cnt;
        w_push       = 1'b0;
        w_push_ev    = make_event(EV_PRESS, r_held_code);

        unique case (r_state)
            ST_IDLE: begin
                w_win_next = '0;
                w_rep_next = '0;
                if (w_accept) begin
                    w_push       = 1'b1;
                    w_push_ev    = make_event(EV_PRESS, w_cmd);
                    w_held_next  = w_cmd;
                    w_state_next = ST_HELD_DELAY;
                end
            end
            ST_HELD_DELAY, ST_HELD_REPEAT: begin
                w_win_next = r_win_cnt + 1'b1;
                w_rep_next = w_rep_inc;
                // Strobe outranks expiry and repeat; a starved repeat fires on
                // the next cycle because the compare is >=.
                if (w_accept) begin
                    if (w_cmd == r_held_code) begin
                        w_win_next = '0;
                    end else begin
                        w_push       = 1'b1;
                        w_push_ev    = make_event(EV_RELEASE, r_held_code);
                        w_held_next  = w_cmd;
                        w_state_next = ST_PRESS_PEND;
                    end
                end else if (r_win_cnt == WIN_LAST) begin
                    w_push       = 1'b1;
                    w_push_ev    = make_event(EV_RELEASE, r_held_code);
                    w_state_next = ST_IDLE;
                end else if (r_rep_cnt >= w_rep_last) begin
                    w_push       = 1'b1;
                    w_push_ev    = make_event(EV_REPEAT, r_held_code);
                    w_rep_next   = '0;
                    w_state_next = ST_HELD_REPEAT;
                end
            end
            ST_PRESS_PEND: begin
                w_push       = 1'b1;
                w_push_ev    = make_event(EV_PRESS, r_held_code);
                w_win_next   = '0;
                w_rep_next   = '0;
                w_state_next = ST_HELD_DELAY;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values computed above.
    always_ff @(posedge i_CLOCK_POS) begin
        if (i_RESET_POS) begin
            r_state         <= ST_IDLE;
            r_frame_ready_d <= 1'b0;
            r_held_code     <= '0;
            r_win_cnt       <= '0;
            r_rep_cnt       <= '0;
        end else begin
            r_state         <= w_state_next;
            r_frame_ready_d <= i_FRAME_READY;
            r_held_code     <= w_held_next;
            r_win_cnt       <= w_win_next;
            r_rep_cnt       <= w_rep_next;
        end
    end

    always_ff @(posedge i_CLOCK_POS) begin
        if (i_RESET_POS) begin
            r_overflow   <= 1'b0;
            r_reject_cnt <= '0;
        end else begin
            if (w_push && w_fifo_full && !w_pop) r_overflow <= 1'b1;
            else if (i_CLEAR_OVF)                r_overflow <= 1'b0;

            if (w_strobe && !w_frame_ok && r_reject_cnt != 8'hFF)
                r_reject_cnt <= r_reject_cnt + 1'b1;
        end
    end

    assign w_pop = !w_fifo_empty && i_EVENT_READY;

    ir_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(ir_event_t))
    ) u_fifo (
        .i_clk   (i_CLOCK_POS),
        .i_rst   (i_RESET_POS),
        .i_push  (w_push),
        .i_data  (w_push_ev),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // Head fields are masked while empty so the port reads zero after reset.
    assign o_EVENT_VALID  = !w_fifo_empty;
    assign o_EVENT_TYPE   = w_fifo_empty ? 2'b00 : w_head.ev_type;
    assign o_EVENT_CODE   = w_fifo_empty ? 8'h00 : w_head.code;
    assign o_KEY_HELD     = (r_state == ST_HELD_DELAY) || (r_state == ST_HELD_REPEAT);
    assign o_HELD_CODE    = r_held_code;
    assign o_OVERFLOW     = r_overflow;
    assign o_REJECT_COUNT = r_reject_cnt;

endmodule

// File: tb/tb_ir_key_scheduler.sv
// Scoreboard bench for ir_key_scheduler: stimulus queues expected events with
// their arrival cycle, a negedge monitor pops and compares accepted events.
module tb_ir_key_scheduler;
    import ir_pkg::*;

    localparam logic [31:0] F45     = 32'hBA45FF00;
    localparam logic [31:0] F40     = 32'hBF40FF00;
    localparam logic [31:0] F_BAD_N = 32'hBA45FE00;
    localparam logic [31:0] F_BAD_A = 32'hBA4500FF;

    logic        clk = 1'b0;
    logic        i_RESET_POS = 1'b1;
    logic        i_FRAME_READY = 1'b0;
    logic [31:0] i_FRAME = '0;
    logic        i_EVENT_READY = 1'b1;
    logic        i_CLEAR_OVF = 1'b0;
    logic        o_EVENT_VALID;
    logic [1:0]  o_EVENT_TYPE;
    logic [7:0]  o_EVENT_CODE;
    logic        o_KEY_HELD;
    logic [7:0]  o_HELD_CODE;
    logic        o_OVERFLOW;
    logic [7:0]  o_REJECT_COUNT;

    ir_key_scheduler #(
        .DEVICE_ADDR    (8'h00),
        .ADDR_FILTER_EN (1'b1),
        .HOLD_WINDOW    (100),
        .REPEAT_DELAY   (50),
        .REPEAT_PERIOD  (20),
        .FIFO_DEPTH     (4)
    ) dut (
        .i_CLOCK_POS    (clk),
        .i_RESET_POS    (i_RESET_POS),
        .i_FRAME_READY  (i_FRAME_READY),
        .i_FRAME        (i_FRAME),
        .i_EVENT_READY  (i_EVENT_READY),
        .i_CLEAR_OVF    (i_CLEAR_OVF),
        .o_EVENT_VALID  (o_EVENT_VALID),
        .o_EVENT_TYPE   (o_EVENT_TYPE),
        .o_EVENT_CODE   (o_EVENT_CODE),
        .o_KEY_HELD     (o_KEY_HELD),
        .o_HELD_CODE    (o_HELD_CODE),
        .o_OVERFLOW     (o_OVERFLOW),
        .o_REJECT_COUNT (o_REJECT_COUNT)
    );

    always #5 clk = ~clk;

    // Edge counter: at the negedge after edge k it reads k.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0] t;
        logic [7:0] c;
        int         at;   // expected arrival cycle, -1 when timing is not checked
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_ev(input logic [1:0] t, input logic [7:0] c, input int at);
        exp_t e;
        e.t  = t;
        e.c  = c;
        e.at = at;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!i_RESET_POS && o_EVENT_VALID && i_EVENT_READY) begin
            if (sb.size() == 0) begin
                check("unexpected_event", {22'd0, o_EVENT_TYPE, o_EVENT_CODE}, 32'hFFFF_FFFF);
            end else begin
                mon_e = sb.pop_front();
                check("ev_type", 32'(o_EVENT_TYPE), 32'(mon_e.t));
                check("ev_code", 32'(o_EVENT_CODE), 32'(mon_e.c));
                if (mon_e.at >= 0) check("ev_cycle", 32'(cyc), 32'(mon_e.at));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int k);
        while (cyc < k) tick(1);
    endtask

    // Strobe edge is cyc+1 at call time; the level is held for five cycles.
    task automatic send_frame(input logic [31:0] f);
        i_FRAME       = f;
        i_FRAME_READY = 1'b1;
        tick(5);
        i_FRAME_READY = 1'b0;
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int t1;
        int p;

        tick(3);
        i_RESET_POS = 1'b0;
        check("rst_valid",  32'(o_EVENT_VALID),  32'd0);
        check("rst_held",   32'(o_KEY_HELD),     32'd0);
        check("rst_code",   32'(o_HELD_CODE),    32'd0);
        check("rst_ovf",    32'(o_OVERFLOW),     32'd0);
        check("rst_reject", 32'(o_REJECT_COUNT), 32'd0);
        tick(2);

        // Single frame: PRESS, repeats at +50/+70/+90, release at +100.
        t0 = cyc + 1;
        expect_ev(EV_PRESS, 8'h45, t0);
        for (int k = 50; k < 100; k += 20) expect_ev(EV_REPEAT, 8'h45, t0 + k);
        expect_ev(EV_RELEASE, 8'h45, t0 + 100);
        send_frame(F45);
        check("t1_held",      32'(o_KEY_HELD),  32'd1);
        check("t1_held_code", 32'(o_HELD_CODE), 32'h45);
        wait_until(t0 + 99);
        check("t1_held_last", 32'(o_KEY_HELD), 32'd1);
        wait_until(t0 + 100);
        check("t1_released",  32'(o_KEY_HELD), 32'd0);
        tick(10);

        // Frame every 80 cycles, 4 times: repeats continue, release 100 after last.
        t0 = cyc + 1;
        expect_ev(EV_PRESS, 8'h45, t0);
        for (int k = 50; k <= 330; k += 20) expect_ev(EV_REPEAT, 8'h45, t0 + k);
        expect_ev(EV_RELEASE, 8'h45, t0 + 340);
        send_frame(F45);
        for (int i = 1; i < 4; i++) begin
            wait_until(t0 + 80 * i - 1);
            send_frame(F45);
        end
        wait_until(t0 + 339);
        check("t2_held_last", 32'(o_KEY_HELD), 32'd1);
        wait_until(t0 + 341);
        check("t2_released",  32'(o_KEY_HELD), 32'd0);
        tick(5);

        // Key change: RELEASE 45 and PRESS 40 on consecutive cycles.
        t0 = cyc + 1;
        t1 = t0 + 30;
        p  = t1 + 1;
        expect_ev(EV_PRESS,   8'h45, t0);
        expect_ev(EV_RELEASE, 8'h45, t1);
        expect_ev(EV_PRESS,   8'h40, p);
        for (int k = 50; k < 100; k += 20) expect_ev(EV_REPEAT, 8'h40, p + k);
        expect_ev(EV_RELEASE, 8'h40, p + 100);
        send_frame(F45);
        wait_until(t1 - 1);
        send_frame(F40);
        check("t3_held_code", 32'(o_HELD_CODE), 32'h40);
        check("t3_held",      32'(o_KEY_HELD),  32'd1);
        wait_until(p + 101);
        check("t3_released",  32'(o_KEY_HELD),  32'd0);
        tick(5);

        // Rejected frames: counted, no events, no hold.
        send_frame(F_BAD_N);
        tick(3);
        send_frame(F_BAD_A);
        tick(3);
        check("t4_reject", 32'(o_REJECT_COUNT), 32'd2);
        check("t4_held",   32'(o_KEY_HELD),     32'd0);
        check("t4_valid",  32'(o_EVENT_VALID),  32'd0);

        // Stalled consumer: four events fit, the fifth overflows.
        i_EVENT_READY = 1'b0;
        t0 = cyc + 1;
        expect_ev(EV_PRESS, 8'h45, -1);
        for (int k = 0; k < 3; k++) expect_ev(EV_REPEAT, 8'h45, -1);
        send_frame(F45);
        wait_until(t0 + 79);
        send_frame(F45);
        wait_until(t0 + 109);
        check("t5_ovf_before", 32'(o_OVERFLOW),    32'd0);
        check("t5_valid",      32'(o_EVENT_VALID), 32'd1);
        wait_until(t0 + 110);
        check("t5_ovf_set",    32'(o_OVERFLOW),    32'd1);
        i_CLEAR_OVF = 1'b1;
        tick(1);
        i_CLEAR_OVF = 1'b0;
        check("t5_ovf_clear",  32'(o_OVERFLOW),    32'd0);
        wait_until(t0 + 129);
        i_CLEAR_OVF = 1'b1;
        tick(1);
        i_CLEAR_OVF = 1'b0;
        check("t5_ovf_wins",   32'(o_OVERFLOW),    32'd1);
        wait_until(t0 + 185);
        check("t5_held_off",   32'(o_KEY_HELD),    32'd0);
        i_CLEAR_OVF = 1'b1;
        tick(1);
        i_CLEAR_OVF = 1'b0;
        check("t5_ovf_clear2", 32'(o_OVERFLOW),    32'd0);
        i_EVENT_READY = 1'b1;
        tick(8);
        check("t5_drained",    32'(o_EVENT_VALID), 32'd0);

        // Reset in HELD_REPEAT with two events queued: everything discarded.
        i_EVENT_READY = 1'b0;
        t0 = cyc + 1;
        send_frame(F45);
        wait_until(t0 + 55);
        check("t6_held_pre",  32'(o_KEY_HELD),    32'd1);
        check("t6_valid_pre", 32'(o_EVENT_VALID), 32'd1);
        i_RESET_POS = 1'b1;
        tick(1);
        i_RESET_POS = 1'b0;
        check("t6_valid",  32'(o_EVENT_VALID),  32'd0);
        check("t6_held",   32'(o_KEY_HELD),     32'd0);
        check("t6_reject", 32'(o_REJECT_COUNT), 32'd0);
        check("t6_ovf",    32'(o_OVERFLOW),     32'd0);
        i_EVENT_READY = 1'b1;
        tick(150);
        check("t6_no_events", 32'(o_EVENT_VALID), 32'd0);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
